life_hud_ctrl: RTL
==================

Name: life_hud_ctrl

Overview:
- Sequences the life-icon sprite ROM (40x39 pixels, 1560 entries, 11-bit address, 1-cycle registered read, 24-bit RGB out) to draw a row of remaining-life icons on the VGA HUD.
- Owns the player lives counter and the game-over flag.
- Plays a blink animation on the lost icon after each hit.
- Sits between the VGA controller's DrawX/DrawY and the colour mapper. It is the only master of the ROM address port.

Parameters:
- ICON_W, 40, sprite width in pixels
- ICON_H, 39, sprite height in pixels
- HUD_X, 16, left x of icon 0
- HUD_Y, 8, top y of icons
- GAP, 4, horizontal pixels between icons
- MAX_LIVES, 5, lives saturation value and number of icon slots
- START_LIVES, 3, lives loaded on game_start
- BLINK_FRAMES, 32, frames spent in HIT_BLINK
- TRANSPARENT, 24'hffffff, ROM colour treated as see-through

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- DrawX  in  10  current VGA pixel x
- DrawY  in  10  current VGA pixel y
- frame_tick  in  1  one-cycle pulse per frame (vsync start)
- game_start  in  1  pulse; loads START_LIVES
- life_lost  in  1  pulse; player hit
- life_gain  in  1  pulse; extra life pickup
- rom_addr  out  11  read address to sprite ROM
- rom_data  in  24  ROM output, valid one cycle after rom_addr
- pixel_on  out  1  HUD pixel opaque this cycle
- pixel_rgb  out  24  HUD pixel colour
- lives  out  3  current lives
- game_over  out  1  high in OVER state
- hit_busy  out  1  high in HIT_BLINK

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high. Reset has priority over all inputs, including mid-blink and mid-line.
- Reset values: state=IDLE, lives=0, game_over=0, hit_busy=0, rom_addr=0, pixel_on=0, pixel_rgb=0, blink counter=0, pipeline valid bits=0.
- State machine states: IDLE, PLAY, HIT_BLINK, OVER.
- IDLE -> PLAY on game_start; lives<=START_LIVES.
- PLAY:
  - life_lost alone: lives<=lives-1, blink counter<=0, go to HIT_BLINK.
  - life_gain alone: lives<=min(lives+1,MAX_LIVES).
  - Both in the same cycle: no change.
- HIT_BLINK:
  - Counter increments on each frame_tick.
  - When counter reaches BLINK_FRAMES-1 and frame_tick is high: go to OVER if lives==0, else go to PLAY.
  - life_lost and life_gain are ignored (invulnerability).
- OVER: game_over=1. game_start -> PLAY with START_LIVES.
- game_start in PLAY or HIT_BLINK restarts: lives<=START_LIVES, state<=PLAY.
- Lives never underflow; the PLAY decrement only happens when lives>=1.
- Visible icon count: lives. In HIT_BLINK, slot index lives (the lost icon) is also drawn when blink counter bit 2 == 0, so it toggles every 4 frames.
- Hit test (stage 1, registered at the edge sampling DrawX/DrawY):
  - Slot i x range: HUD_X+i*(ICON_W+GAP) to +ICON_W-1.
  - y range: HUD_Y to HUD_Y+ICON_H-1.
  - The slot must be visible. Pixels in a GAP are misses.
  - Local col = DrawX - slot base; row = DrawY - HUD_Y.
  - rom_addr <= row*ICON_W + col, 11-bit, maximum 1559. rom_addr holds its previous value on a miss.
- Stage 2: hit flag delayed one cycle to align with rom_data.
- Stage 3 (registered): pixel_on <= hit_d && rom_data != TRANSPARENT. pixel_rgb <= rom_data if pixel_on, else 0.
- Latency: DrawX/DrawY sampled at edge t produce pixel_on/pixel_rgb after edge t+2, i.e. 3-cycle total pipeline. Fully pipelined, one pixel per clock, no stalls.
- Visibility is evaluated from lives/state at stage 1. A change of lives mid-frame takes effect from the next sampled pixel.

Test Plan:
- Reset:
  - Stimulus: assert Reset for 2 cycles while DrawX=20, DrawY=10.
  - Required: pixel_on=0, lives=0, game_over=0, state IDLE. No icon drawn in IDLE.
- Addressing:
  - Stimulus: game_start; DrawX=HUD_X+ICON_W+GAP+5=65, DrawY=HUD_Y+2=10.
  - Required: rom_addr=2*40+5=85 one cycle later. With rom model returning 24'heb8b7d, pixel_on=1 and pixel_rgb=24'heb8b7d 3 cycles after sample.
- Gap, transparency and hidden slots:
  - DrawX=57 (gap) -> pixel_on=0.
  - ROM returns 24'hffffff -> pixel_on=0.
  - Slot 3 with lives=3 -> pixel_on=0.
- Hit and blink:
  - Stimulus: lives=3, life_lost pulse.
  - Required: lives=2 and hit_busy=1 next cycle. Slot 2 is drawn in frames 0-3, hidden in 4-7. A second life_lost during the blink leaves lives=2. After 32 frame_ticks, back in PLAY with hit_busy=0.
- Saturation and simultaneous pulses:
  - 3 life_gain pulses from lives=3 -> lives=5.
  - life_lost and life_gain in the same cycle -> lives unchanged and state PLAY.
- Game over and reset:
  - From lives=1, life_lost and 32 frames -> game_over=1, lives=0. game_start -> lives=3, game_over=0.
  - Reset asserted mid-HIT_BLINK -> IDLE next cycle.

Source files
------------

// File: rtl/life_hud_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : life_hud_ctrl
//  Description : Lives counter, game-over flag and life-icon HUD sequencer.
//                Drives the life-icon sprite ROM address from DrawX/DrawY,
//                aligns the ROM output with a hit flag and produces a keyed
//                HUD pixel for the colour mapper. Plays a blink animation on
//                the lost icon while the player is invulnerable after a hit.
//
//  Ports       : Clk, Reset       - clock, synchronous active-high reset
//                DrawX, DrawY     - current VGA pixel coordinate
//                frame_tick       - one pulse per frame
//                game_start       - (re)start with START_LIVES
//                life_lost        - player hit pulse
//                life_gain        - extra life pulse
//                rom_addr         - sprite ROM read address (1-cycle ROM)
//                rom_data         - sprite ROM colour
//                pixel_on         - HUD pixel opaque
//                pixel_rgb        - HUD pixel colour (0 when not opaque)
//                lives            - current lives
//                game_over        - high in OVER
//                hit_busy         - high while the hit blink plays
//
//  Revision    : 1.0 - initial release
// ============================================================================
module life_hud_ctrl #(
    parameter int          ICON_W       = 40,
    parameter int          ICON_H       = 39,
    parameter int          HUD_X        = 16,
    parameter int          HUD_Y        = 8,
    parameter int          GAP          = 4,
    parameter int          MAX_LIVES    = 5,
    parameter int          START_LIVES  = 3,
    parameter int          BLINK_FRAMES = 32,
    parameter logic [23:0] TRANSPARENT  = 24'hffffff
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        frame_tick,
    input  logic        game_start,
    input  logic        life_lost,
    input  logic        life_gain,
    output logic [10:0] rom_addr,
    input  logic [23:0] rom_data,
    output logic        pixel_on,
    output logic [23:0] pixel_rgb,
    output logic [2:0]  lives,
    output logic        game_over,
    output logic        hit_busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_pitch   = ICON_W + GAP;
    // Blink counter needs at least bit 2 for the 4-frame toggle.
    localparam int c_blink_w = ($clog2(BLINK_FRAMES) > 3) ? $clog2(BLINK_FRAMES) : 3;

    localparam logic [c_blink_w-1:0] c_blink_last = c_blink_w'(BLINK_FRAMES - 1);
    localparam logic [2:0]           c_start      = 3'(START_LIVES);
    localparam logic [2:0]           c_max        = 3'(MAX_LIVES);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_play = 2'd1;
    localparam logic [1:0] c_st_hit  = 2'd2;
    localparam logic [1:0] c_st_over = 2'd3;

    // ------------------------------------------------------------------------
    // Game state machine
    // ------------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [1:0]           w_state_nxt;
    logic [2:0]           r_lives;
    logic [2:0]           w_lives_nxt;
    logic [c_blink_w-1:0] r_blink;
    logic [c_blink_w-1:0] w_blink_nxt;
    logic                 w_game_over;
    logic                 w_hit_busy;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state <= c_st_idle;
            r_lives <= 3'd0;
            r_blink <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lives <= w_lives_nxt;
            r_blink <= w_blink_nxt;
        end
    end

    // Next-state logic. A restart wins over every other event in any state.
    always_comb begin
        w_state_nxt = r_state;
        w_lives_nxt = r_lives;
        w_blink_nxt = r_blink;

        if (game_start) begin
            w_state_nxt = c_st_play;
            w_lives_nxt = c_start;
            w_blink_nxt = '0;
        end else begin
            case (r_state)
                c_st_play: begin
                    // Simultaneous hit and pickup cancel each other out.
                    if (life_lost && !life_gain) begin
                        if (r_lives != 3'd0) begin
                            w_lives_nxt = r_lives - 3'd1;
                            w_blink_nxt = '0;
                            w_state_nxt = c_st_hit;
                        end
                    end else if (life_gain && !life_lost) begin
                        if (r_lives < c_max) begin
                            w_lives_nxt = r_lives + 3'd1;
                        end
                    end
                end
                c_st_hit: begin
                    // Hits and pickups are ignored while blinking.
                    if (frame_tick) begin
                        if (r_blink == c_blink_last) begin
                            w_state_nxt = (r_lives == 3'd0) ? c_st_over : c_st_play;
                        end else begin
                            w_blink_nxt = r_blink + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State-decoded outputs
    always_comb begin
        w_game_over = 1'b0;
        w_hit_busy  = 1'b0;
        case (r_state)
            c_st_over: w_game_over = 1'b1;
            c_st_hit:  w_hit_busy  = 1'b1;
            default: begin
            end
        endcase
    end

    assign lives     = r_lives;
    assign game_over = w_game_over;
    assign hit_busy  = w_hit_busy;

    // ------------------------------------------------------------------------
    // Stage 1: per-slot hit test and ROM address generation
    // ------------------------------------------------------------------------
    logic [9:0]  w_row;
    logic        w_in_y;
    logic        w_slot_hit  [MAX_LIVES];
    logic [10:0] w_slot_addr [MAX_LIVES];
    logic        w_hit;
    logic [10:0] w_addr;

    assign w_row  = DrawY - 10'(HUD_Y);
    assign w_in_y = (DrawY >= 10'(HUD_Y)) && (DrawY <= 10'(HUD_Y + ICON_H - 1));

    for (genvar i = 0; i < MAX_LIVES; i++) begin : g_slot
        localparam int         c_base = HUD_X + i * c_pitch;
        localparam logic [2:0] c_idx  = 3'(i);

        logic [9:0] w_col;
        logic       w_in_x;
        logic       w_vis;

        assign w_col  = DrawX - 10'(c_base);
        assign w_in_x = (DrawX >= 10'(c_base)) && (DrawX <= 10'(c_base + ICON_W - 1));

        // Slots below the life count are always shown; the slot of the life
        // just lost is shown on even 4-frame phases of the blink.
        assign w_vis = (c_idx < r_lives) ||
                       ((r_state == c_st_hit) && (c_idx == r_lives) && !r_blink[2]);

        assign w_slot_hit[i]  = w_in_x && w_in_y && w_vis;
        assign w_slot_addr[i] = 11'(w_row) * 11'(ICON_W) + 11'(w_col);
    end

    // Slots are disjoint in x, so at most one can hit. A miss keeps the
    // previous address to avoid needless ROM address toggling.
    always_comb begin
        w_hit  = 1'b0;
        w_addr = rom_addr;
        for (int k = 0; k < MAX_LIVES; k++) begin
            if (w_slot_hit[k]) begin
                w_hit  = 1'b1;
                w_addr = w_slot_addr[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Pipeline: stage 1 address/hit, stage 2 hit delay, stage 3 colour key
    // ------------------------------------------------------------------------
    logic        r_hit_s1;
    logic        r_hit_s2;
    logic        r_pix_on;
    logic [23:0] r_pix_rgb;
    logic [10:0] r_rom_addr;
    logic        w_opaque;

    assign w_opaque = r_hit_s2 && (rom_data != TRANSPARENT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rom_addr <= 11'd0;
            r_hit_s1   <= 1'b0;
            r_hit_s2   <= 1'b0;
            r_pix_on   <= 1'b0;
            r_pix_rgb  <= 24'd0;
        end else begin
            r_rom_addr <= w_addr;
            r_hit_s1   <= w_hit;
            r_hit_s2   <= r_hit_s1;
            r_pix_on   <= w_opaque;
            r_pix_rgb  <= w_opaque ? rom_data : 24'd0;
        end
    end

    assign rom_addr  = r_rom_addr;
    assign pixel_on  = r_pix_on;
    assign pixel_rgb = r_pix_rgb;

endmodule
`default_nettype wire
